wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter g_num_masters, default 4: number of requesting Wishbone masters (2..8).
REQ-002 Parameter g_aw, default 32: address width.
REQ-003 Parameter g_dw, default 32: data width; select width is g_dw/8.
REQ-004 Parameter g_timeout, default 255: watchdog limit in cycles; 0 disables the watchdog.
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk_i  in  1  sole clock, all state on rising edge.
REQ-007 rst_n_i  in  1  asynchronous active-low reset.
REQ-008 m_adr_i  in  N*g_aw  master addresses, master k at bits [k*g_aw +: g_aw]; m_dat_i (N*g_dw) and m_sel_i (N*g_dw/8) are packed the same way.
REQ-009 m_we_i, m_cyc_i, m_stb_i  in  N  per-master classic Wishbone controls, bit k = master k.
REQ-010 m_dat_o  out  g_dw  read data, s_dat_i broadcast to all masters.
REQ-011 m_ack_o, m_err_o  out  N  per-master termination.
REQ-012 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  g_aw/g_dw/g_dw/8/1/1/1  shared slave port.
REQ-013 s_dat_i, s_ack_i, s_err_i  in  g_dw/1/1  slave response.
REQ-014 grant_o  out  N  registered one-hot grant; busy_o  out  1  high in BUSY or ABORT.

Function
REQ-015 FSM SHALL have states IDLE, BUSY, ABORT; a last_grant index SHALL be registered.
REQ-016 IDLE: if any m_cyc_i bit is high at a rising edge, the arbiter SHALL grant the first requester searching from last_grant+1 upward, modulo N, and enter BUSY.
REQ-017 Grant latency SHALL be exactly one cycle: cyc sampled at edge k -> grant_o and s_cyc_o high after edge k.
REQ-018 BUSY: s_adr/dat/sel/we/cyc/stb SHALL be combinational copies of the granted master's signals.
REQ-019 BUSY: s_ack_i/s_err_i SHALL be routed only to the granted master's m_ack_o/m_err_o; non-granted masters SHALL see 0 (they stall).
REQ-020 BUSY -> IDLE when the granted master's m_cyc_i is low at a rising edge; grant_o clears and last_grant updates.
REQ-021 Handover SHALL therefore always insert exactly one IDLE cycle, giving a 2-cycle gap between consecutive grants.
REQ-022 IDLE and ABORT: s_cyc_o and s_stb_o SHALL be 0; s_ack_i/s_err_i SHALL be ignored; all m_ack_o/m_err_o SHALL be 0 (except the REQ-024 error pulse).
REQ-023 Watchdog counter (clog2(g_timeout+1) bits) SHALL clear in IDLE, when s_stb_o is low, or on s_ack_i/s_err_i; otherwise it increments in BUSY, saturating.
REQ-024 When the counter equals g_timeout, the arbiter SHALL assert m_err_o of the granted master for exactly one cycle and enter ABORT at the next edge.
REQ-025 ABORT: grant_o SHALL be held; exit to IDLE when the granted master's m_cyc_i is low.
REQ-026 An s_ack_i in the same cycle the counter reaches g_timeout SHALL win: ack is forwarded, no error is raised, and the counter clears.
REQ-027 If g_timeout=0 the watchdog SHALL never fire.
REQ-028 A master that drops m_cyc_i mid-transfer SHALL release the bus per REQ-020 regardless of a pending ack.

Reset
REQ-029 On rst_n_i low the arbiter SHALL immediately, without a clock, set: state=IDLE, grant_o=0, busy_o=0, counter=0, last_grant=N-1 (master 0 has first priority), and all m_ack_o/m_err_o and s_cyc_o/s_stb_o low.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer; after release the arbiter SHALL arbitrate afresh from master 0.

Verification
REQ-031 After reset, masters 0 and 2 both raise cyc on the same edge -> grant_o=0001 next cycle; after master 0 completes its write, one IDLE cycle, then grant_o=0100.
REQ-032 All 4 masters hold cyc continuously, each doing one write -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
REQ-033 Master 1 writes 0xDEADBEEF to 0x40 through a memory BFM slave -> memory word 0x10 = 0xDEADBEEF; only m_ack_o[1] pulses.
REQ-034 g_timeout=8 and a slave that never acks -> m_err_o[granted] pulses 8 cycles after stb, s_cyc_o drops, FSM=ABORT until that master's cyc falls.
REQ-035 Ack arrives on the exact timeout cycle -> ack forwarded, m_err_o stays 0.
REQ-036 rst_n_i pulsed low while master 3 is granted -> grant_o=0 asynchronously; next request from masters 1 and 3 -> grant master 1.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port between
// several masters, with a bus watchdog that aborts a stuck transfer.
module wb_rr_arbiter #(
   parameter int unsigned g_num_masters = 4,
   parameter int unsigned g_aw          = 32,
   parameter int unsigned g_dw          = 32,
   parameter int unsigned g_timeout     = 255
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   // master side
   input  logic [g_num_masters*g_aw-1:0]       m_adr_i,
   input  logic [g_num_masters*g_dw-1:0]       m_dat_i,
   input  logic [g_num_masters*(g_dw/8)-1:0]   m_sel_i,
   input  logic [g_num_masters-1:0]            m_we_i,
   input  logic [g_num_masters-1:0]            m_cyc_i,
   input  logic [g_num_masters-1:0]            m_stb_i,
   output logic [g_dw-1:0]                     m_dat_o,
   output logic [g_num_masters-1:0]            m_ack_o,
   output logic [g_num_masters-1:0]            m_err_o,
   // slave side
   output logic [g_aw-1:0]                     s_adr_o,
   output logic [g_dw-1:0]                     s_dat_o,
   output logic [g_dw/8-1:0]                   s_sel_o,
   output logic                                s_we_o,
   output logic                                s_cyc_o,
   output logic                                s_stb_o,
   input  logic [g_dw-1:0]                     s_dat_i,
   input  logic                                s_ack_i,
   input  logic                                s_err_i,
   // status
   output logic [g_num_masters-1:0]            grant_o,
   output logic                                busy_o
);

   localparam int unsigned N     = g_num_masters;
   localparam int unsigned SW    = g_dw / 8;
   localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW    = (g_timeout > 0) ? $clog2(g_timeout + 1) : 1;
   localparam bit          WD_EN = (g_timeout != 0);
   localparam logic [CW-1:0] TO_VAL   = CW'(g_timeout);
   localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } state_t;

   state_t        state;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] pick_idx;
   logic          pick_valid;
   logic [CW-1:0] wd_cnt;
   logic          wd_fire;
   logic          gnt_cyc;
   logic          gnt_stb;
   logic          in_busy;

   // Round-robin pick: first requester after the last owner, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         if (!pick_valid && m_cyc_i[IW'((32'(last_grant) + i) % N)]) begin
            pick_valid = 1'b1;
            pick_idx   = IW'((32'(last_grant) + i) % N);
         end
      end
   end

   // Select the granted master's request signals.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      gnt_cyc = 1'b0;
      gnt_stb = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (gnt_idx == IW'(k)) begin
            s_adr_o = m_adr_i[k*g_aw +: g_aw];
            s_dat_o = m_dat_i[k*g_dw +: g_dw];
            s_sel_o = m_sel_i[k*SW +: SW];
            s_we_o  = m_we_i[k];
            gnt_cyc = m_cyc_i[k];
            gnt_stb = m_stb_i[k];
         end
      end
   end

   assign in_busy = (state == BUSY);
   assign s_cyc_o = in_busy & gnt_cyc;
   assign s_stb_o = in_busy & gnt_stb;
   assign m_dat_o = s_dat_i;

   // A slave ack on the limit cycle beats the watchdog.
   assign wd_fire = WD_EN && in_busy && (wd_cnt == TO_VAL) && !s_ack_i;

   // Route slave termination to the owner only; everyone else stalls.
   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      if (in_busy) begin
         m_ack_o[gnt_idx] = s_ack_i;
         m_err_o[gnt_idx] = s_err_i | wd_fire;
      end
   end

   // Watchdog: counts unanswered strobe cycles, saturating at the limit.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wd_cnt <= '0;
      end else if (!in_busy || !s_stb_o || s_ack_i || s_err_i || !WD_EN) begin
         wd_cnt <= '0;
      end else if (wd_cnt != TO_VAL) begin
         wd_cnt <= wd_cnt + CW'(1);
      end
   end

   // Arbitration FSM with registered grant, busy and last-owner index.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         gnt_idx    <= '0;
         last_grant <= LAST_RST;
         grant_o    <= '0;
         busy_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state   <= BUSY;
                  gnt_idx <= pick_idx;
                  grant_o <= N'(1) << pick_idx;
                  busy_o  <= 1'b1;
               end
            end
            BUSY: begin
               if (!gnt_cyc) begin
                  state      <= IDLE;
                  grant_o    <= '0;
                  busy_o     <= 1'b0;
                  last_grant <= gnt_idx;
               end else if (wd_fire) begin
                  state <= ABORT;
               end
            end
            ABORT: begin
               if (!gnt_cyc) begin
                  state      <= IDLE;
                  grant_o    <= '0;
                  busy_o     <= 1'b0;
                  last_grant <= gnt_idx;
               end
            end
            default: begin
               state   <= IDLE;
               grant_o <= '0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level owner/queue model.
module tb_wb_rr_arbiter;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int          TO = 8;

   logic clk = 1'b0;
   logic rst_n;

   logic [NM-1:0] m_cyc, m_stb, m_we;
   logic [AW-1:0] adr [NM];
   logic [DW-1:0] dat [NM];
   logic [3:0]    sel [NM];

   logic [NM*AW-1:0] m_adr_bus;
   logic [NM*DW-1:0] m_dat_bus;
   logic [NM*4-1:0]  m_sel_bus;

   logic [DW-1:0] m_dat_o;
   logic [NM-1:0] m_ack_o, m_err_o, grant_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [3:0]    s_sel_o;
   logic          s_we_o, s_cyc_o, s_stb_o, busy_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i, s_err_i;

   assign m_adr_bus = {adr[3], adr[2], adr[1], adr[0]};
   assign m_dat_bus = {dat[3], dat[2], dat[1], dat[0]};
   assign m_sel_bus = {sel[3], sel[2], sel[1], sel[0]};

   always #5 clk = ~clk;

   wb_rr_arbiter #(
      .g_num_masters(NM), .g_aw(AW), .g_dw(DW), .g_timeout(TO)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m_adr_i(m_adr_bus), .m_dat_i(m_dat_bus), .m_sel_i(m_sel_bus),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: current owner (-1 none), aborted flag, last owner,
   // cycles the owner's strobe has gone unanswered
   int owner, last, wait_n;
   bit aborted;

   logic [31:0]   mem [256];
   logic [NM-1:0] obs_ack, obs_err, exp_ack, exp_err;
   logic          obs_scyc;

   // slave BFM response scheduling for random traffic
   bit sl_busy, sl_err;
   int sl_cnt, sl_delay;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit on_bus();
      if (owner < 0 || aborted) return 1'b0;
      return m_cyc[2'(owner)] && m_stb[2'(owner)];
   endfunction

   task automatic model_reset();
      owner   = -1;
      aborted = 1'b0;
      last    = NM - 1;
      wait_n  = 0;
      exp_ack = '0;
      exp_err = '0;
      sl_busy = 1'b0;
   endtask

   task automatic set_m(input int k, input bit c, input bit s, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
      m_cyc[2'(k)] = c;
      m_stb[2'(k)] = s;
      m_we[2'(k)]  = w;
      adr[2'(k)]   = a;
      dat[2'(k)]   = d;
      sel[2'(k)]   = 4'hF;
   endtask

   task automatic slave_drive(input bit ack, input bit err);
      s_ack_i = ack;
      s_err_i = err;
      if (on_bus()) s_dat_i = mem[adr[2'(owner)][9:2]];
      else          s_dat_i = 32'($urandom);
   endtask

   // One bus cycle: predict, sample at negedge, advance model at posedge.
   task automatic step();
      logic [NM-1:0] eg, eack, eerr;
      logic          escyc, esstb, eb;
      bit            act, tmo, wr;
      int            o, nw;
      logic [7:0]    wa;
      logic [31:0]   wd;
      logic [3:0]    ws;
      o     = owner;
      act   = (owner >= 0) && !aborted;
      eb    = (owner >= 0);
      eg    = (owner >= 0) ? (4'(1) << owner) : 4'd0;
      escyc = act && m_cyc[2'(o)];
      esstb = act && m_stb[2'(o)];
      tmo   = act && (wait_n == TO) && !s_ack_i;
      eack  = (act && s_ack_i) ? eg : 4'd0;
      eerr  = (act && (s_err_i || tmo)) ? eg : 4'd0;
      @(negedge clk);
      check("grant", 64'(grant_o), 64'(eg));
      check("busy",  64'(busy_o),  64'(eb));
      check("s_cyc", 64'(s_cyc_o), 64'(escyc));
      check("s_stb", 64'(s_stb_o), 64'(esstb));
      check("m_ack", 64'(m_ack_o), 64'(eack));
      check("m_err", 64'(m_err_o), 64'(eerr));
      check("m_dat", 64'(m_dat_o), 64'(s_dat_i));
      if (escyc) begin
         check("s_adr", 64'(s_adr_o), 64'(adr[2'(o)]));
         check("s_dat", 64'(s_dat_o), 64'(dat[2'(o)]));
         check("s_sel", 64'(s_sel_o), 64'(sel[2'(o)]));
         check("s_we",  64'(s_we_o),  64'(m_we[2'(o)]));
      end
      obs_ack  = m_ack_o;
      obs_err  = m_err_o;
      obs_scyc = s_cyc_o;
      exp_ack  = eack;
      exp_err  = eerr;
      wr = s_cyc_o && s_stb_o && s_we_o && s_ack_i;
      wa = s_adr_o[9:2];
      wd = s_dat_o;
      ws = s_sel_o;
      @(posedge clk);
      if (wr)
         for (int b = 0; b < 4; b++)
            if (ws[b]) mem[wa][b*8 +: 8] = wd[b*8 +: 8];
      nw = (act && m_stb[2'(o)] && !s_ack_i && !s_err_i) ? ((wait_n < TO) ? wait_n + 1 : TO) : 0;
      if (owner < 0) begin
         for (int i = 1; i <= NM; i++) begin
            int c;
            c = (last + i) % NM;
            if (m_cyc[2'(c)]) begin
               owner = c;
               break;
            end
         end
      end else if (!m_cyc[2'(owner)]) begin
         last    = owner;
         owner   = -1;
         aborted = 1'b0;
      end else if (tmo) begin
         aborted = 1'b1;
      end
      wait_n = nw;
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      m_cyc   = '0;
      m_stb   = '0;
      m_we    = '0;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Random master behaviour for one cycle, driven by last cycle's outcome.
   task automatic rand_masters();
      for (int k = 0; k < NM; k++) begin
         if (m_cyc[2'(k)]) begin
            if (exp_ack[2'(k)]) begin
               m_cyc[2'(k)] = 1'b0;
               m_stb[2'(k)] = 1'b0;
            end else if (exp_err[2'(k)]) begin
               m_stb[2'(k)] = 1'b0;
               if ($urandom % 2 == 0) m_cyc[2'(k)] = 1'b0;
            end else if (owner == k && aborted) begin
               if ($urandom % 3 == 0) m_cyc[2'(k)] = 1'b0;
            end else if (!m_stb[2'(k)] || ($urandom % 60 == 0)) begin
               m_cyc[2'(k)] = 1'b0;
               m_stb[2'(k)] = 1'b0;
            end
         end else if ($urandom % 4 == 0) begin
            set_m(k, 1'b1, 1'b1, 1'($urandom), {22'd0, 8'($urandom), 2'b00}, 32'($urandom));
            sel[2'(k)] = 4'($urandom);
         end
      end
   endtask

   // Random slave: fixed delays, an exact-timeout ack, a never-ack, or an error.
   task automatic rand_slave();
      bit ack, err;
      int r;
      ack = 1'b0;
      err = 1'b0;
      if (on_bus()) begin
         if (!sl_busy) begin
            sl_busy = 1'b1;
            sl_cnt  = 0;
            sl_err  = 1'b0;
            r = int'($urandom % 16);
            if (r < 6)        sl_delay = 0;
            else if (r < 10)  sl_delay = 1;
            else if (r < 12)  sl_delay = 2;
            else if (r == 12) sl_delay = 3;
            else if (r == 13) sl_delay = TO;
            else if (r == 14) sl_delay = 99;
            else begin
               sl_delay = 1;
               sl_err   = 1'b1;
            end
         end
         if (sl_cnt == sl_delay) begin
            ack     = !sl_err;
            err     = sl_err;
            sl_busy = 1'b0;
         end else begin
            sl_cnt++;
         end
      end else begin
         sl_busy = 1'b0;
         if ((owner < 0 || aborted) && ($urandom % 8 == 0)) begin
            ack = 1'($urandom);
            err = !ack;
         end
      end
      slave_drive(ack, err);
   endtask

   initial begin
      int order[$];
      int gaps[$];
      int exp_ord[5];
      int zeros, lat, gi, bus_cnt;
      int ack_cnt[NM];
      logic [NM-1:0] prev_g, errs;

      exp_ord = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 256; i++) mem[i] = 32'($urandom);
      for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_dat_i = '0;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_grant", 64'(grant_o), 64'd0);
      check("rst_busy",  64'(busy_o),  64'd0);
      check("rst_scyc",  64'(s_cyc_o), 64'd0);
      check("rst_sstb",  64'(s_stb_o), 64'd0);
      check("rst_ack",   64'(m_ack_o), 64'd0);
      check("rst_err",   64'(m_err_o), 64'd0);
      @(posedge clk);
      apply_reset();

      // masters 0 and 2 together: 0 first, one idle cycle, then 2
      set_m(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1111_1111);
      set_m(2, 1'b1, 1'b1, 1'b1, 32'h8, 32'h2222_2222);
      slave_drive(1'b0, 1'b0); step();
      check("r31_g0", 64'(grant_o), 64'h1);
      slave_drive(1'b1, 1'b0); step();
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slave_drive(1'b0, 1'b0); step();
      check("r31_idle", 64'(grant_o), 64'h0);
      slave_drive(1'b0, 1'b0); step();
      check("r31_g2", 64'(grant_o), 64'h4);
      slave_drive(1'b1, 1'b0); step();
      set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slave_drive(1'b0, 1'b0); step();

      // all four requesting continuously: strict rotation with one idle gap
      apply_reset();
      for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(k * 4), 32'hA0 + 32'(k));
      zeros  = 0;
      prev_g = '0;
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         for (int k = 0; k < NM; k++) begin
            m_cyc[2'(k)] = !exp_ack[2'(k)];
            m_stb[2'(k)] = !exp_ack[2'(k)];
         end
         slave_drive(on_bus(), 1'b0);
         step();
         if (grant_o != 4'd0) begin
            if (grant_o != prev_g) begin
               gi = -1;
               for (int k = 0; k < NM; k++) if (grant_o[k]) gi = k;
               order.push_back(gi);
               if (order.size() > 1) gaps.push_back(zeros);
            end
            zeros = 0;
         end else begin
            zeros++;
         end
         prev_g = grant_o;
      end
      check("r32_count", 64'(order.size()), 64'd5);
      for (int i = 0; i < order.size() && i < 5; i++) check("r32_order", 64'(order[i]), 64'(exp_ord[i]));
      for (int i = 0; i < gaps.size(); i++) check("r32_gap", 64'(gaps[i]), 64'd1);
      m_cyc = '0;
      m_stb = '0;
      slave_drive(1'b0, 1'b0); step();
      step();

      // master 1 writes DEADBEEF to 0x40 through the memory slave
      apply_reset();
      mem[16] = 32'h0;
      for (int k = 0; k < NM; k++) ack_cnt[k] = 0;
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      bus_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (exp_ack[1]) begin
            m_cyc[1] = 1'b0;
            m_stb[1] = 1'b0;
         end
         if (on_bus()) begin
            slave_drive(bus_cnt == 1, 1'b0);
            bus_cnt++;
         end else begin
            slave_drive(1'b0, 1'b0);
         end
         step();
         for (int k = 0; k < NM; k++) ack_cnt[k] += int'(obs_ack[k]);
      end
      check("r33_mem",   64'(mem[16]), 64'hDEAD_BEEF);
      check("r33_ack1",  64'(ack_cnt[1]), 64'd1);
      check("r33_ackoth", 64'(ack_cnt[0] + ack_cnt[2] + ack_cnt[3]), 64'd0);

      // slave never answers: error after TO strobe cycles, then ABORT
      apply_reset();
      set_m(2, 1'b1, 1'b1, 1'b1, 32'h80, 32'h3333_3333);
      slave_drive(1'b0, 1'b0); step();
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         slave_drive(1'b0, 1'b0); step();
         if (obs_err[2]) lat = i;
      end
      check("r34_lat", 64'(lat), 64'(TO));
      slave_drive(1'b0, 1'b0); step();
      check("r34_pulse", 64'(obs_err), 64'd0);
      check("r34_scyc",  64'(obs_scyc), 64'd0);
      check("r34_busy",  64'(busy_o), 64'd1);
      check("r34_hold",  64'(grant_o), 64'h4);
      slave_drive(1'b1, 1'b0); step();
      check("r34_ign", 64'(obs_ack), 64'd0);
      slave_drive(1'b0, 1'b1); step();
      check("r34_ignerr", 64'(obs_err), 64'd0);
      check("r34_hold2", 64'(grant_o), 64'h4);
      set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slave_drive(1'b0, 1'b0); step();
      check("r34_rel", 64'(grant_o), 64'h0);

      // ack on the exact limit cycle wins over the watchdog
      apply_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
      slave_drive(1'b0, 1'b0); step();
      errs = '0;
      for (int i = 0; i <= TO; i++) begin
         slave_drive(i == TO, 1'b0); step();
         errs |= obs_err;
         if (i == TO) check("r35_ack", 64'(obs_ack), 64'h1);
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slave_drive(1'b0, 1'b0); step();
      errs |= obs_err;
      check("r35_noerr", 64'(errs), 64'd0);
      check("r35_rel", 64'(busy_o), 64'd0);

      // asynchronous reset while master 3 owns the bus
      apply_reset();
      set_m(3, 1'b1, 1'b1, 1'b1, 32'hC0, 32'h4444_4444);
      slave_drive(1'b0, 1'b0); step();
      check("r36_pre", 64'(grant_o), 64'h8);
      #2 rst_n = 1'b0;
      #1;
      check("r36_gnt",  64'(grant_o), 64'd0);
      check("r36_busy", 64'(busy_o),  64'd0);
      check("r36_scyc", 64'(s_cyc_o), 64'd0);
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h5555_5555);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      slave_drive(1'b0, 1'b0); step();
      check("r36_g1", 64'(grant_o), 64'h2);
      m_cyc = '0;
      m_stb = '0;
      slave_drive(1'b0, 1'b0); step();
      step();

      // random traffic against the model
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         rand_masters();
         rand_slave();
         step();
      end
      m_cyc = '0;
      m_stb = '0;
      slave_drive(1'b0, 1'b0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
